// File: rtl/bus_ram_slave.sv
// bus_ram_slave: bus-tree leaf slave that terminates a command stream on an
// external single-port synchronous RAM. Commands are executed in order; each
// one produces a response that passes through a one-entry pipe register (so
// read data can be collected one cycle after the RAM access) and then a small
// FIFO that lets the master back-pressure responses. A credit check on
// command acceptance ensures the FIFO can never overflow.
module bus_ram_slave #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 10,
    parameter int RESP_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2:0]                  MCmd,
    input  logic [ADDR_WIDTH-1:0]       MAddr,
    input  logic [DATA_WIDTH-1:0]       MData,
    input  logic [DATA_WIDTH/8-1:0]     MByteEn,
    output logic                        SCmdAccept,
    output logic [1:0]                  SResp,
    output logic [DATA_WIDTH-1:0]       SData,
    input  logic                        MRespAccept,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [DATA_WIDTH/8-1:0]     ram_be,
    output logic [RAM_ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]       ram_wdata,
    input  logic [DATA_WIDTH-1:0]       ram_rdata
);

    localparam int PTR_WIDTH = $clog2(RESP_DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    localparam logic [2:0] CMD_IDLE = 3'd0;
    localparam logic [2:0] CMD_WR   = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;

    typedef enum logic [1:0] {
        RESP_NULL = 2'd0,
        RESP_DVA  = 2'd1,
        RESP_ERR  = 2'd3
    } resp_e;

    // Pipe stage between RAM access and FIFO push.
    logic                  pipe_valid_q, pipe_valid_d;
    logic                  pipe_is_read_q, pipe_is_read_d;
    resp_e                 pipe_resp_q, pipe_resp_d;

    // Response FIFO.
    resp_e                 fifo_resp_q [RESP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [RESP_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    logic [CNT_WIDTH:0]    credit_used;
    logic                  in_range;
    logic                  is_wr, is_rd;
    logic                  cmd_take;
    logic                  head_valid;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] push_data;

    // Credits in use are the queued responses plus the one in the pipe stage;
    // depends only on registers and reset, never on the current command.
    assign credit_used = {1'b0, count_q} + (CNT_WIDTH+1)'(pipe_valid_q);
    assign SCmdAccept  = !reset && (credit_used < (CNT_WIDTH+1)'(RESP_DEPTH));

    assign in_range = (MAddr[ADDR_WIDTH-1:RAM_ADDR_WIDTH] == '0);
    assign is_wr    = (MCmd == CMD_WR);
    assign is_rd    = (MCmd == CMD_RD);
    assign cmd_take = SCmdAccept && (MCmd != CMD_IDLE);

    // The RAM is driven in the accept cycle itself; out-of-range and reserved
    // commands never touch it.
    assign ram_en    = cmd_take && in_range && (is_wr || is_rd);
    assign ram_we    = ram_en && is_wr;
    assign ram_be    = ram_we ? MByteEn : '0;
    assign ram_addr  = MAddr[RAM_ADDR_WIDTH-1:0];
    assign ram_wdata = MData;

    // Head of the FIFO is presented directly; reset forces NULL/0 immediately.
    assign head_valid = !reset && (count_q != '0);
    assign SResp      = head_valid ? fifo_resp_q[rd_ptr_q] : RESP_NULL;
    assign SData      = head_valid ? fifo_data_q[rd_ptr_q] : '0;

    assign push      = pipe_valid_q;
    assign pop       = head_valid && MRespAccept;
    assign push_data = pipe_is_read_q ? ram_rdata : '0;

    // Next-state for the pipe stage, pointers and occupancy.
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    always_comb begin
        pipe_valid_d   = cmd_take;
        pipe_is_read_d = cmd_take && in_range && is_rd;
        pipe_resp_d    = (in_range && (is_wr || is_rd)) ? RESP_DVA : RESP_ERR;
        wr_ptr_d       = wr_ptr_q + PTR_WIDTH'(push);
        rd_ptr_d       = rd_ptr_q + PTR_WIDTH'(pop);
        count_d        = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end

    // Control registers; reset drops everything in flight.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_q   <= 1'b0;
            pipe_is_read_q <= 1'b0;
            pipe_resp_q    <= RESP_NULL;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            pipe_valid_q   <= pipe_valid_d;
            pipe_is_read_q <= pipe_is_read_d;
            pipe_resp_q    <= pipe_resp_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // FIFO storage, written on push; read data is captured here for reads.
    // NOTE: storage is not reset; an entry is only ever observed after a push has written it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_resp_q[wr_ptr_q] <= pipe_resp_q;
            fifo_data_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
